// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and hex-to-segment table for the seven-segment scan driver
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK   = 7'h7F;
    localparam int         DIGIT_COUNT = 4;

    // Active-low segments, bit order g,f,e,d,c,b,a
    function automatic logic [6:0] hex2seg(input logic [3:0] hex);
        logic [6:0] s;
        case (hex)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to active-low segment decoder
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Pure table lookup; the table lives in the package so the bench-facing values stay in one place
    always_comb begin
        seg = hex2seg(hex);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed seven-segment driver with frame shadowing, blanking and PWM
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int PHASE_LEN = 12500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] disp_in,
    input  logic        blank_lz,
    input  logic [2:0]  bright,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int CW = $clog2(PHASE_LEN);
    localparam int IW = $clog2(DIGIT_COUNT);

    logic [CW-1:0] cnt;
    logic [2:0]    phase;
    logic [IW-1:0] idx;
    logic [15:0]   shadow;
    logic          loadPend;

    logic          cntWrap;
    logic          frameEnd;
    logic [3:0]    nibble;
    logic [3:0]    zeroNib;
    logic [3:0]    leadZero;
    logic          blankDigit;
    logic [6:0]    segDecoded;
    logic [3:0]    anNext;

    assign cntWrap  = (cnt == CW'(PHASE_LEN - 1));
    assign frameEnd = cntWrap && (phase == 3'd7) && (idx == IW'(DIGIT_COUNT - 1));

    // Phase/digit scan counters: cnt paces a brightness phase, 8 phases make a digit slot
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            phase <= '0;
            idx   <= '0;
        end else if (cntWrap) begin
            cnt   <= '0;
            phase <= phase + 3'd1;
            if (phase == 3'd7) begin
                idx <= idx + IW'(1);
            end
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Shadow copy of the display word, refreshed only at the frame boundary so digits never tear
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
        end else if (frameEnd) begin
            shadow <= disp_in;
        end
    end

    // Per-nibble zero flags and the leading-zero chain from the top digit downward; digit 0 always shows
    always_comb begin
        nibble   = shadow[{idx, 2'b00} +: 4];
        zeroNib  = {shadow[15:12] == 4'h0, shadow[11:8] == 4'h0,
                    shadow[7:4] == 4'h0, shadow[3:0] == 4'h0};
        leadZero = 4'b0000;
        leadZero[3] = zeroNib[3];
        leadZero[2] = zeroNib[2] & leadZero[3];
        leadZero[1] = zeroNib[1] & leadZero[2];
        blankDigit  = blank_lz & leadZero[idx];
        anNext      = (phase <= bright) ? ~(4'b0001 << idx) : 4'hF;
    end

    seg7_hex_decode uDecode (
        .hex (nibble),
        .seg (segDecoded)
    );

    // Output registers: an and seg switch on the same edge; frame_tick is delayed one extra
    // stage through loadPend so it coincides with the first digit-0 output of the new frame
    always_ff @(posedge clk) begin
        if (reset) begin
            an         <= 4'hF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            loadPend   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            an         <= anNext;
            seg        <= blankDigit ? SEG_BLANK : segDecoded;
            dp         <= 1'b1;
            loadPend   <= frameEnd;
            frame_tick <= loadPend;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] disp_in;
    logic        blank_lz;
    logic [2:0]  bright;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.PHASE_LEN(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .disp_in    (disp_in),
        .blank_lz   (blank_lz),
        .bright     (bright),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        nTests++;
        assert (observed === expected) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkDigit(input string tag, input int d, input logic [6:0] expSeg);
        logic [3:0] expAn;
        expAn    = 4'hF;
        expAn[d] = 1'b0;
        check({tag, "_an"}, {12'h0, an}, {12'h0, expAn});
        check({tag, "_seg"}, {9'h0, seg}, {9'h0, expSeg});
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_an"}, {12'h0, an}, 16'h000F);
        check({tag, "_seg"}, {9'h0, seg}, 16'h007F);
        check({tag, "_dp"}, {15'h0, dp}, 16'h0001);
        check({tag, "_tick"}, {15'h0, frame_tick}, 16'h0000);
    endtask

    // Counts anode-low cycles over one digit slot; lowExp cycles, all at the start of the slot
    task automatic checkPwmSlot(input string tag, input int d, input int lowExp, input logic lastSlot);
        logic [3:0] expAn;
        int low, early, high;
        expAn    = 4'hF;
        expAn[d] = 1'b0;
        low = 0; early = 0; high = 0;
        for (int i = 0; i < 16; i++) begin
            if (an == expAn) begin
                low++;
                if (i < lowExp) early++;
            end
            if (an == 4'hF) high++;
            if (lastSlot && i == 15) bright = 3'd0;
            tick(1);
        end
        check({tag, "_low"}, 16'(low), 16'(lowExp));
        check({tag, "_early"}, 16'(early), 16'(lowExp));
        check({tag, "_high"}, 16'(high), 16'(16 - lowExp));
    endtask

    initial begin
        reset    = 1'b1;
        disp_in  = 16'h0000;
        blank_lz = 1'b0;
        bright   = 3'd7;

        // Reset values
        tick(3);
        checkReset("reset");

        // First frame after reset shows shadow = 0 on every digit
        disp_in = 16'h8A1F;
        reset   = 1'b0;
        tick(1);
        check("f1_tick0", {15'h0, frame_tick}, 16'h0000);
        for (int d = 0; d < 4; d++) begin
            checkDigit("f1_zero", d, 7'h40);
            tick(16);
        end

        // Scan order for 8A1F, checked at both ends of each slot
        check("f2_tick", {15'h0, frame_tick}, 16'h0001);
        disp_in = 16'h1111;
        tick(1);
        check("f2_tick_pulse", {15'h0, frame_tick}, 16'h0000);
        checkDigit("f2_d0_start", 0, 7'h0E);
        tick(14);
        checkDigit("f2_d0_end", 0, 7'h0E);
        tick(1);
        checkDigit("f2_d1_start", 1, 7'h79);
        tick(15);
        checkDigit("f2_d1_end", 1, 7'h79);
        tick(1);
        checkDigit("f2_d2_start", 2, 7'h08);
        tick(15);
        checkDigit("f2_d2_end", 2, 7'h08);
        tick(1);
        checkDigit("f2_d3_start", 3, 7'h00);
        tick(15);
        checkDigit("f2_d3_end", 3, 7'h00);
        tick(1);

        // Tear-free: change to EEEE inside digit 1, the frame must keep 1111
        check("f3_tick", {15'h0, frame_tick}, 16'h0001);
        checkDigit("f3_d0", 0, 7'h79);
        tick(16);
        checkDigit("f3_d1", 1, 7'h79);
        tick(4);
        disp_in = 16'hEEEE;
        tick(12);
        checkDigit("f3_d2", 2, 7'h79);
        tick(16);
        checkDigit("f3_d3", 3, 7'h79);
        tick(16);

        // EEEE frame; a value presented only on the load cycle must be captured
        check("f4_tick", {15'h0, frame_tick}, 16'h0001);
        checkDigit("f4_d0", 0, 7'h06);
        tick(16);
        checkDigit("f4_d1", 1, 7'h06);
        tick(16);
        checkDigit("f4_d2", 2, 7'h06);
        tick(16);
        checkDigit("f4_d3", 3, 7'h06);
        tick(14);
        disp_in = 16'h00A0;
        tick(1);
        disp_in  = 16'hFFFF;
        blank_lz = 1'b1;
        tick(1);

        // Leading-zero blanking of 00A0, anodes still scanning
        check("f5_tick", {15'h0, frame_tick}, 16'h0001);
        disp_in = 16'h0000;
        checkDigit("f5_d0", 0, 7'h40);
        tick(16);
        checkDigit("f5_d1", 1, 7'h08);
        tick(16);
        checkDigit("f5_d2", 2, 7'h7F);
        tick(16);
        checkDigit("f5_d3", 3, 7'h7F);
        tick(16);

        // All-zero word with blanking: only digit 0 lit
        check("f6_tick", {15'h0, frame_tick}, 16'h0001);
        checkDigit("f6_d0", 0, 7'h40);
        tick(16);
        checkDigit("f6_d1", 1, 7'h7F);
        tick(16);
        checkDigit("f6_d2", 2, 7'h7F);
        tick(16);
        checkDigit("f6_d3", 3, 7'h7F);
        tick(15);
        bright = 3'd2;
        tick(1);

        // PWM: bright=2 gives 6 of 16 cycles, then bright=0 gives 2 of 16
        check("f7_tick", {15'h0, frame_tick}, 16'h0001);
        for (int d = 0; d < 4; d++) begin
            checkPwmSlot("pwm2", d, 6, d == 3);
        end
        check("f8_tick", {15'h0, frame_tick}, 16'h0001);
        for (int d = 0; d < 4; d++) begin
            checkPwmSlot("pwm0", d, 2, 1'b0);
        end

        // Mid-frame reset during digit 2
        check("f9_tick", {15'h0, frame_tick}, 16'h0001);
        tick(37);
        reset = 1'b1;
        tick(1);
        checkReset("midreset");
        reset    = 1'b0;
        bright   = 3'd7;
        blank_lz = 1'b0;
        disp_in  = 16'h1234;
        tick(1);
        check("restart_tick0", {15'h0, frame_tick}, 16'h0000);
        checkDigit("restart_d0", 0, 7'h40);
        tick(16);
        checkDigit("restart_d1", 1, 7'h40);
        tick(16);
        checkDigit("restart_d2", 2, 7'h40);
        tick(16);
        checkDigit("restart_d3", 3, 7'h40);
        tick(16);
        check("restart_tick", {15'h0, frame_tick}, 16'h0001);
        checkDigit("restart_next_d0", 0, 7'h19);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a 4-digit common-anode seven-segment display, consuming the 16-bit `dispBufferOut` word from the CPU top level. Each nibble is shown as one hex digit, rightmost digit = bits [3:0]. The block samples the word once per frame so that digits never tear. It also provides leading-zero blanking and 8-level brightness PWM. It sits between `CPU_top` and the board pins.

## Interface

Parameters:
- `PHASE_LEN`, default 12500: clock cycles per brightness phase. Must be ≥ 2. One digit slot = 8·`PHASE_LEN` cycles; one frame = 32·`PHASE_LEN` cycles.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `disp_in`  in  16  display word, driven from `dispBufferOut`.
- `blank_lz`  in  1  1 = blank leading zero digits.
- `bright`  in  3  brightness: anode duty = (`bright`+1)/8 of each slot.
- `an`  out  4  anodes, active-low; `an[0]` = rightmost digit.
- `seg`  out  7  cathodes, active-low, `seg[6:0]` = g,f,e,d,c,b,a.
- `dp`  out  1  decimal point, active-low; always driven 1 (off).
- `frame_tick`  out  1  one-cycle pulse when the shadow register reloads.

## Operation

- **Counters**
  - `cnt` counts 0..`PHASE_LEN`-1.
  - On wrap, the 3-bit `phase` increments.
  - On `phase` wrap 7→0, the 2-bit digit index `idx` increments and wraps 3→0.
- **Shadow register**
  - `shadow` loads `disp_in` on the cycle where `idx`=3, `phase`=7 and `cnt`=`PHASE_LEN`-1 (end of frame).
  - `disp_in` is ignored at all other times.
  - `frame_tick`=1 on that same cycle's registered output, i.e. one cycle after the load decision, together with the first output of digit 0.
- **Nibble select:** nibble = `shadow[4·idx+3 : 4·idx]`.
- **Leading-zero blanking**
  - Digit k (k = 1..3) is blanked when `blank_lz`=1 and `shadow` nibbles k..3 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit drives `seg`=7'h7F with its anode still following PWM.
- **Decode:** hex to segments. 0→7'h40, 1→7'h79, 8→7'h00, A→7'h08, E→7'h06, F→7'h0E. All 16 values are defined.
- **PWM:** anode `idx` is active (0) when `phase` ≤ `bright`; all other anodes are always 1. `bright`=7 gives full duty; `bright`=0 gives 1/8 duty (never fully off).
- `bright` and `blank_lz` are used live each cycle and are not shadowed.
- **Reset**
  - Registers: `cnt`=0, `phase`=0, `idx`=0, `shadow`=0.
  - Outputs: `an`=4'hF, `seg`=7'h7F, `dp`=1, `frame_tick`=0.
  - Reset asserted mid-frame aborts the scan immediately; the next cycle's outputs are the reset values.
  - The first frame after reset displays `shadow`=0, i.e. "0000", or "   0" with `blank_lz`.

## Timing

- All outputs are registered: pins reflect counter/shadow state with 1-cycle latency.
- `an` changes on the cycle after the `phase`/`idx` transition.
- `seg` and `an` switch on the same edge, so no inter-digit glitch is permitted.
- `disp_in` to visible latency: ≤ 1 frame + 1 cycle.
- `disp_in` changes within a frame never alter the current frame's digits.
- A `disp_in` change on the exact load cycle is captured.
- `frame_tick` period is exactly 32·`PHASE_LEN` cycles after the first frame boundary.

## Structure

- Package `seg7_pkg` contains:
  - `SEG_BLANK` = 7'h7F;
  - the 16-entry hex→segment constant table, or a function `hex2seg`;
  - a digit count constant of 4.
- Sub-module `seg7_hex_decode`: combinational 4→7 decoder using the package table.
- Top level `seg7_scan_driver` contains the counters, shadow register, blanking logic, PWM compare and output registers.

## Test plan

All scenarios use `PHASE_LEN`=2 (slot 16 cycles, frame 64 cycles).
- **Reset:** hold `reset` 3 cycles → `an`=F, `seg`=7F, `dp`=1, `frame_tick`=0. First frame with `bright`=7, `blank_lz`=0 shows `seg`=40 on every digit.
- **Scan order:** `disp_in`=16'h8A1F, `bright`=7 → after the first `frame_tick`, `an` sequence E,D,B,7 with `seg` 0E,79,08,00. Each digit is held 16 cycles; `frame_tick` recurs every 64 cycles.
- **Tear-free:** change `disp_in` 16'h1111→16'hEEEE mid-frame → the current frame keeps `seg`=79 on all digits; the next frame shows 06.
- **Blanking:** `disp_in`=16'h00A0, `blank_lz`=1 → digits 3 and 2 show `seg`=7F, digit 1=08, digit 0=40. `disp_in`=0 → only digit 0 is lit, showing 40.
- **PWM:** `bright`=2 → each anode is low for exactly 6 of its 16 cycles (phases 0-2), then high for 10. `bright`=0 → low for 2 cycles.
- **Mid-frame reset:** assert `reset` during digit 2 → outputs return to reset values next cycle. Scan restarts at digit 0 with `shadow`=0.
